// File: rtl/dvb_cfg_regbank.sv
// Double-buffered configuration register bank: the host edits a shadow bank, and the
// modulator sees an active bank that is reloaded only on a frame-aligned commit or a forced copy.
module dvb_cfg_regbank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int OPT_MEM_ADDR_BITS  = 10,
   parameter int NUM_REGS           = 16,
   parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   wen,
   input  logic [OPT_MEM_ADDR_BITS-1:0]           waddr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        wstrb,
   input  logic                                   ren,
   input  logic [OPT_MEM_ADDR_BITS-1:0]           raddr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          rdata,
   output logic                                   rvalid,
   input  logic                                   frame_boundary,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_active,
   output logic                                   cfg_update,
   output logic                                   commit_pending
);

   localparam int W  = C_S_AXI_DATA_WIDTH;
   localparam int A  = OPT_MEM_ADDR_BITS;
   localparam int NB = W / 8;
   localparam logic [A-1:0] CTRL_ADDR   = A'(NUM_REGS);
   localparam logic [A-1:0] STATUS_ADDR = A'(NUM_REGS + 1);

   logic [W-1:0]  shadow_r [NUM_REGS];
   logic [W-1:0]  active_r [NUM_REGS];
   logic          commit_pending_r;
   logic [15:0]   commit_count_r;
   logic          cfg_update_r;
   logic [W-1:0]  rdata_r;
   logic          rvalid_r;

   logic          ctrl_wr_s;
   logic          commit_req_s;
   logic          force_req_s;
   logic          copy_s;
   logic          pending_next_s;
   logic [W-1:0]  rd_mux_s;

   function automatic logic [W-1:0] byte_merge(
      input logic [W-1:0]  old_v,
      input logic [W-1:0]  new_v,
      input logic [NB-1:0] strb
   );
      logic [W-1:0] res;
      res = old_v;
      for (int b = 0; b < NB; b++) begin
         res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return res;
   endfunction

   // Decode CTRL writes and decide the next commit state; FORCE beats COMMIT, a fresh COMMIT re-arms.
   always_comb begin
      ctrl_wr_s    = wen && (waddr == CTRL_ADDR);
      commit_req_s = ctrl_wr_s && wstrb[0] && wdata[0];
      force_req_s  = ctrl_wr_s && wstrb[0] && wdata[1];
      copy_s       = force_req_s || (frame_boundary && commit_pending_r);
      if (force_req_s) begin
         pending_next_s = 1'b0;
      end else if (commit_req_s) begin
         pending_next_s = 1'b1;
      end else if (copy_s) begin
         pending_next_s = 1'b0;
      end else begin
         pending_next_s = commit_pending_r;
      end
   end

   // Read address decode; anything not matched returns the unmapped marker.
   always_comb begin
      rd_mux_s = W'({16'hE000, 16'(raddr)});
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_mux_s = (raddr == A'(i))       ? shadow_r[i] : rd_mux_s;
         rd_mux_s = (raddr == A'(256 + i)) ? active_r[i] : rd_mux_s;
      end
      rd_mux_s = (raddr == CTRL_ADDR) ? {W{1'b0}} : rd_mux_s;
      rd_mux_s = (raddr == STATUS_ADDR) ? W'({commit_count_r, 15'd0, commit_pending_r}) : rd_mux_s;
   end

   // Shadow/active banks and commit bookkeeping; the active copy samples shadow before this edge's write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_r[i] <= RESET_VALUES[i*W +: W];
            active_r[i] <= RESET_VALUES[i*W +: W];
         end
         commit_pending_r <= 1'b0;
         commit_count_r   <= 16'd0;
         cfg_update_r     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wen && (waddr == A'(i))) begin
               shadow_r[i] <= byte_merge(shadow_r[i], wdata, wstrb);
            end
            if (copy_s) begin
               active_r[i] <= shadow_r[i];
            end
         end
         commit_pending_r <= pending_next_s;
         cfg_update_r     <= copy_s;
         if (copy_s) begin
            commit_count_r <= commit_count_r + 16'd1;
         end
      end
   end

   // Registered read port: one-cycle latency, data held until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r  <= {W{1'b0}};
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= ren;
         if (ren) begin
            rdata_r <= rd_mux_s;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_active
      assign cfg_active[g*W +: W] = active_r[g];
   end

   assign rdata          = rdata_r;
   assign rvalid         = rvalid_r;
   assign cfg_update     = cfg_update_r;
   assign commit_pending = commit_pending_r;

endmodule
